// File: rtl/gps_speed_conv.sv
// gps_speed_conv: converts five ASCII knots*100 digits from the speed RAM to km/h*10 binary and packed BCD
// Ports: clk, rst (sync, active-low); start/gps_valid request a conversion from IDLE;
//   sh_rd_addr/sh_rd_data read the registered speed RAM (data one cycle after address);
//   kmh_bin (km/h*10), kmh_bcd (5 packed BCD digits), spd_ok, err hold the last result;
//   busy is high outside IDLE; done pulses for the cycle in which the outputs update.
// Build option: define SPD_CLAMP_EN to saturate the result at 999 (99.9 km/h) for a 4-digit display.
module gps_speed_conv #(
    parameter int MUL_K  = 1517,
    parameter int MUL_SH = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        gps_valid,
    output logic [3:0]  sh_rd_addr,
    input  logic [7:0]  sh_rd_data,
    output logic [14:0] kmh_bin,
    output logic [19:0] kmh_bcd,
    output logic        spd_ok,
    output logic        err,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, RD, MUL, BCD, DONE} state_t;
    localparam logic [10:0] K = 11'(MUL_K);
    state_t state, state_n;
    logic [3:0]  cnt;
    logic [16:0] acc;
    logic [27:0] prod;
    logic [19:0] bcd, bcd_adj, bcd_sh, res_bcd;
    logic [14:0] bin, res_bin;
    logic        digit;
    always_comb begin
        digit = sh_rd_data >= 8'h30 && sh_rd_data <= 8'h39;
        bin = 15'(prod >> MUL_SH);
        for (int i = 0; i < 5; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        // the top nibble never overflows for results up to 18517, so the bit shifted out is always 0
        bcd_sh = 20'({bcd_adj, bin[4'd14 - cnt]});
`ifdef SPD_CLAMP_EN
        res_bin = bin > 15'd999 ? 15'd999 : bin;
        res_bcd = bin > 15'd999 ? 20'h00999 : bcd_sh;
`else
        res_bin = bin;
        res_bcd = bcd_sh;
`endif
        state_n = state;
        case (state)
            IDLE: state_n = start ? (gps_valid ? RD : DONE) : IDLE;
            // cycle 0 only issues address 0; from cycle 1 the byte for the previous address is checked
            RD:   state_n = cnt != 4'd0 && !digit ? DONE : cnt == 4'd5 ? MUL : RD;
            MUL:  state_n = cnt == 4'd10 ? BCD : MUL;
            BCD:  state_n = cnt == 4'd14 ? DONE : BCD;
            default: state_n = IDLE;
        endcase
    end
    // a bad byte parks the address at 0 in the cycle it is seen, so no further reads go out
    assign sh_rd_addr = state == RD && cnt <= 4'd4 && (cnt == 4'd0 || digit) ? cnt : 4'd0;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            prod    <= '0;
            bcd     <= '0;
            kmh_bin <= '0;
            kmh_bcd <= '0;
            spd_ok  <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? 4'd0 : cnt + 4'd1;
            done  <= state_n == DONE;
            if (state == IDLE && start) begin
                acc  <= '0;
                prod <= '0;
                bcd  <= '0;
            end
            if (state == RD && cnt != 4'd0 && digit)
                acc <= acc * 17'd10 + {13'd0, sh_rd_data[3:0]};
            if (state == MUL && K[cnt])
                prod <= prod + ({11'd0, acc} << cnt);
            if (state == BCD)
                bcd <= bcd_sh;
            // results land on the edge entering DONE so they are visible alongside done
            if (state_n == DONE) begin
                kmh_bin <= state == BCD ? res_bin : '0;
                kmh_bcd <= state == BCD ? res_bcd : '0;
                spd_ok  <= state == BCD;
                err     <= state == RD;
            end
        end
    end
endmodule

// File: tb/tb_gps_speed_conv.sv
// tb_gps_speed_conv: randomized and directed checks of gps_speed_conv against a latency/result model
module tb_gps_speed_conv;
    typedef struct packed {
        int          L;
        int          lim;
        logic [14:0] bin;
        logic [19:0] bcd;
        logic        ok;
        logic        err;
    } res_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        gps_valid = 1'b0;
    logic [3:0]  sh_rd_addr;
    logic [7:0]  sh_rd_data = 8'h00;
    logic [14:0] kmh_bin;
    logic [19:0] kmh_bcd;
    logic        spd_ok, err, busy, done;
    logic [7:0]  mem [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    res_t        p;
    int          m_c = 0;
    logic        m_done = 1'b0, m_ok = 1'b0, m_err = 1'b0;
    logic [14:0] m_bin = '0;
    logic [19:0] m_bcd = '0;
    always #5 clk = ~clk;
    gps_speed_conv dut (
        .clk(clk), .rst(rst), .start(start), .gps_valid(gps_valid),
        .sh_rd_addr(sh_rd_addr), .sh_rd_data(sh_rd_data),
        .kmh_bin(kmh_bin), .kmh_bcd(kmh_bcd), .spd_ok(spd_ok), .err(err),
        .busy(busy), .done(done)
    );
    always @(posedge clk) sh_rd_data <= mem[sh_rd_addr];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    // whole-conversion outcome straight from the digit rules: value, scaling, decimal digits, latency
    function automatic res_t predict(input logic v);
        res_t r;
        int val, k;
        r = '0;
        if (!v) begin
            r.L = 1;
            return r;
        end
        r.L = 33;
        r.lim = 5;
        r.ok = 1'b1;
        for (int i = 4; i >= 0; i--)
            if (mem[i] < 8'h30 || mem[i] > 8'h39) begin
                r.L = i + 3;
                r.lim = i + 1;
                r.err = 1'b1;
                r.ok = 1'b0;
            end
        if (r.err) return r;
        val = 0;
        for (int i = 0; i < 5; i++) val = val * 10 + int'(mem[i]) - 48;
        k = (val * 1517) / 8192;
`ifdef SPD_CLAMP_EN
        if (k > 999) k = 999;
`endif
        r.bin = 15'(k);
        r.bcd = {4'(k / 10000), 4'(k / 1000 % 10), 4'(k / 100 % 10), 4'(k / 10 % 10), 4'(k % 10)};
        return r;
    endfunction
    always @(posedge clk) begin
        res_t r;
        r = predict(gps_valid);
        if (!rst) begin
            m_c <= 0;
            m_done <= 1'b0;
            m_bin <= '0;
            m_bcd <= '0;
            m_ok <= 1'b0;
            m_err <= 1'b0;
        end else if (m_c == 0) begin
            m_done <= 1'b0;
            if (start) begin
                p <= r;
                m_c <= 1;
                if (r.L == 1) begin
                    m_done <= 1'b1;
                    m_bin <= r.bin;
                    m_bcd <= r.bcd;
                    m_ok <= r.ok;
                    m_err <= r.err;
                end
            end
        end else if (m_c == p.L) begin
            m_c <= 0;
            m_done <= 1'b0;
        end else begin
            m_c <= m_c + 1;
            if (m_c + 1 == p.L) begin
                m_done <= 1'b1;
                m_bin <= p.bin;
                m_bcd <= p.bcd;
                m_ok <= p.ok;
                m_err <= p.err;
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_c != 0);
            chk("done", done, m_done);
            chk("kmh_bin", kmh_bin, m_bin);
            chk("kmh_bcd", kmh_bcd, m_bcd);
            chk("spd_ok", spd_ok, m_ok);
            chk("err", err, m_err);
            chk("sh_rd_addr", sh_rd_addr, (m_c >= 1 && m_c <= p.lim) ? 4'(m_c - 1) : 4'd0);
        end
    end
    task automatic load(input logic [39:0] s);
        for (int i = 0; i < 5; i++) mem[i] = s[39 - 8*i -: 8];
    endtask
    task automatic run(input logic [39:0] s, input logic v, output int lat);
        @(negedge clk);
        load(s);
        start = 1'b1;
        gps_valid = v;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat, nd, n;
        logic [7:0] b;
        foreach (mem[i]) mem[i] = 8'h30;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        chk("rst_bin", kmh_bin, 0);
        chk("rst_bcd", kmh_bcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", sh_rd_addr, 0);
        run("01250", 1'b1, lat);
        chk("lat_01250", lat, 33);
        chk("bin_01250", kmh_bin, 231);
        chk("bcd_01250", kmh_bcd, 20'h00231);
        chk("ok_01250", spd_ok, 1);
        chk("err_01250", err, 0);
        run("99999", 1'b1, lat);
        chk("lat_99999", lat, 33);
`ifdef SPD_CLAMP_EN
        chk("bin_99999", kmh_bin, 999);
        chk("bcd_99999", kmh_bcd, 20'h00999);
`else
        chk("bin_99999", kmh_bin, 18517);
        chk("bcd_99999", kmh_bcd, 20'h18517);
`endif
        run("99999", 1'b0, lat);
        chk("lat_nofix", lat, 1);
        chk("bin_nofix", kmh_bin, 0);
        chk("bcd_nofix", kmh_bcd, 0);
        chk("ok_nofix", spd_ok, 0);
        chk("err_nofix", err, 0);
        chk("addr_nofix", sh_rd_addr, 0);
        run("01250", 1'b1, lat);
        run("0A250", 1'b1, lat);
        chk("lat_bad", lat, 4);
        chk("err_bad", err, 1);
        chk("bin_bad", kmh_bin, 0);
        chk("ok_bad", spd_ok, 0);
        run("00000", 1'b1, lat);
        chk("lat_zero", lat, 33);
        chk("bin_zero", kmh_bin, 0);
        chk("err_zero", err, 0);
        chk("ok_zero", spd_ok, 1);
        @(negedge clk);
        load("01250");
        start = 1'b1;
        gps_valid = 1'b1;
        @(negedge clk);
        nd = 0;
        for (int c = 1; c <= 45; c++) begin
            if (done) nd++;
            start = (c == 10);
            @(negedge clk);
        end
        start = 1'b0;
        chk("one_done", nd, 1);
        chk("bin_restart", kmh_bin, 231);
        load("12345");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_bin", kmh_bin, 0);
        chk("midrst_bcd", kmh_bcd, 0);
        chk("midrst_ok", spd_ok, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst_no_done", nd, 0);
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < 5; i++) mem[i] = 8'h30 + 8'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0)
                for (int i = 0; i < 5; i++) mem[i] = 8'h39;
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 245));
                if (b >= 8'h30) b = b + 8'd10;
                mem[$urandom_range(0, 4)] = b;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start = 1'b1;
            gps_valid = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (busy && n < 60) begin
                start = ($urandom_range(0, 15) == 0);
                gps_valid = 1'($urandom);
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            chk("idle_after_run", busy, 0);
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gps_speed_conv.md
# gps_speed_conv

Downstream consumer of the GNRMC parser's speed RAM. On a `start` pulse it reads the five ASCII speed digits, which are stored as knots×100 with the decimal point already stripped. It converts them to binary km/h×10 with a sequential constant multiply, then to packed BCD with a sequential double-dabble. The results feed the display and telemetry stages.

## Interface
Parameters:
- `MUL_K`, default 1517: km/h scale constant. km/h×10 = (knots×100 × `MUL_K`) >> `MUL_SH`.
- `MUL_SH`, default 13: right-shift applied after the multiply. 1517/8192 = 0.18518.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the `clk` edge).
- `start`  in  1  single-cycle request. Sampled only in IDLE.
- `gps_valid`  in  1  fix-valid flag from the parser, sampled together with `start`.
- `sh_rd_addr`  out  4  speed-RAM read address. Reset value 0.
- `sh_rd_data`  in  8  speed-RAM read data. Registered RAM: valid 1 cycle after the address.
- `kmh_bin`  out  15  speed in km/h×10, binary. Reset value 0.
- `kmh_bcd`  out  20  5 packed BCD digits of `kmh_bin`. Reset value 0.
- `spd_ok`  out  1  last conversion succeeded with a valid fix. Reset value 0.
- `err`  out  1  last conversion hit a non-digit byte. Reset value 0.
- `busy`  out  1  high in every state except IDLE. Reset value 0.
- `done`  out  1  one-cycle pulse when outputs update. Reset value 0.

## Operation
- States: IDLE, RD, MUL, BCD, DONE.
- IDLE:
  - `start`=1 and `gps_valid`=1 → clear the accumulator, go to RD.
  - `start`=1 and `gps_valid`=0 → go to DONE with the result forced to 0, `spd_ok`=0, `err`=0.
  - `start` while busy is ignored and not queued.
- RD (6 cycles):
  - Read-index cycle k = 0..4 drives `sh_rd_addr`=k.
  - The byte returned for address k−1 is checked in cycle k (k = 1..5).
  - Byte in 0x30..0x39: acc = acc×10 + (byte−0x30). acc is 17 bits, max 99999.
  - Any other byte: go directly to DONE with `err`=1, result 0, `spd_ok`=0.
  - Leaves after the byte for address 4 has been accumulated.
- MUL (11 cycles): shift-add over the 11 bits of `MUL_K`, LSB first, into a 28-bit product. Result = product >> `MUL_SH`, truncated (floor) to 15 bits. The maximum is 18517, so no overflow.
- BCD (15 cycles): double-dabble, one result bit per cycle, MSB first. In each cycle, add 3 to every BCD nibble ≥5, then shift.
- DONE (1 cycle):
  - Register `kmh_bin`, `kmh_bcd`, `spd_ok`, `err`.
  - Pulse `done`.
  - Return to IDLE.
- Outputs hold their last values between conversions.

## Timing
- Cycle 0 is the edge that samples `start`.
- Valid fix, all digits legal:
  - RD in cycles 1–6, MUL in cycles 7–17, BCD in cycles 18–32.
  - `done`=1 in cycle 33, outputs updated on the same edge.
- Invalid fix: `done`=1 in cycle 1.
- Bad byte at address j (0..4): `done`=1 in cycle j+3. No RAM reads are issued after the bad byte is detected.
- `busy` is high in cycles 1 through the `done` cycle inclusive, and low the cycle after.
- A new `start` can be accepted in the cycle after `done`.
- Reset mid-conversion: all state and outputs return to their reset values on the next edge, and no `done` is emitted.
- `sh_rd_addr` returns to 0 in IDLE.

## Configuration
- `SPD_CLAMP_EN` defined: if the result is >999, `kmh_bin` is set to 999 and `kmh_bcd` to 0x00999 (99.9 km/h, 4-digit display). The clamp is applied in DONE; the MUL and BCD stages are unchanged.
- `SPD_CLAMP_EN` undefined: full range 0..18517, no clamp.

## Test plan
- Digits "01250", `gps_valid`=1 → `done` in cycle 33, `kmh_bin`=231, `kmh_bcd`=0x00231, `spd_ok`=1, `err`=0.
- Digits "99999" → without clamp: `kmh_bin`=18517, `kmh_bcd`=0x18517. With `SPD_CLAMP_EN`: `kmh_bin`=999, `kmh_bcd`=0x00999.
- `gps_valid`=0 at `start` → `done` in cycle 1, outputs 0, `spd_ok`=0, no RAM reads issued.
- Digits "0A250" → `err`=1 and `done` in cycle 4, result 0. A following run with "00000" gives 0 with `err`=0 and `spd_ok`=1.
- `start` pulsed in cycle 10 of a conversion → ignored, only one `done`. Assert `rst`=0 in cycle 20 of another run → all outputs 0 next cycle, `busy`=0, no `done`.
